mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the address width of all address ports.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ifReq, input, 1, instruction-fetch request (level, held until ifAck).
REQ-005 The block SHALL have port ifAddr, input, ADDR_W, fetch byte address.
REQ-006 The block SHALL have port ifAck, output, 1, one-cycle fetch-complete pulse.
REQ-007 The block SHALL have port ifData, output, 16, fetched word: {MEM[ifAddr+1], MEM[ifAddr]}.
REQ-008 The block SHALL have port dReq, input, 1, data-access request (level, held until dAck).
REQ-009 The block SHALL have port dWe, input, 1, data write (1) or read (0).
REQ-010 The block SHALL have port dAddr, input, ADDR_W, data byte address.
REQ-011 The block SHALL have port dWData, input, 8, data write byte.
REQ-012 The block SHALL have port dAck, output, 1, one-cycle data-complete pulse.
REQ-013 The block SHALL have port dRData, output, 8, data read byte.
REQ-014 The block SHALL have port memAddress, output, ADDR_W, address to the shared single-port memory.
REQ-015 The block SHALL have port memWriteData, output, 8, write byte to the memory.
REQ-016 The block SHALL have port memWriteEnable, output, 1, memory write strobe.
REQ-017 The block SHALL have port memReadData, input, 8, combinational memory read data for memAddress.
REQ-018 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, IF_LO, IF_HI, D_RD, D_WR.
REQ-020 In IDLE, a request is eligible only if its req is high and its own ack is low in that cycle.
REQ-021 One eligible request: grant it. Both eligible: grant the port not granted last (round-robin flag lastGrant).
REQ-022 On grant, the block SHALL latch the granted address, dWe and dWData; requester inputs are ignored until the next IDLE.
REQ-023 Fetch grant: IDLE->IF_LO->IF_HI->IDLE; IF_LO drives memAddress=addr and captures memReadData into ifData[7:0] at its closing edge.
REQ-024 IF_HI drives memAddress=addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and captures ifData[15:8] at its closing edge.
REQ-025 Data read: IDLE->D_RD->IDLE; D_RD drives memAddress=addr, captures memReadData into dRData at closing edge.
REQ-026 Data write: IDLE->D_WR->IDLE; D_WR drives memAddress=addr, memWriteData=latched byte, memWriteEnable=1.
REQ-027 memWriteEnable SHALL be 1 only in D_WR, 0 in all other states.
REQ-028 ifAck/dAck SHALL be registered, high exactly for the one cycle following the final access state (that cycle is IDLE).
REQ-029 Latency: req first eligible in IDLE cycle n -> fetch ack in cycle n+3, data ack in cycle n+2.
REQ-030 Back-to-back: a new grant MAY be issued in the same IDLE cycle in which the other port's ack is high.
REQ-031 ifData and dRData SHALL hold their values until overwritten by the next completion of the same type.
REQ-032 In IDLE, memAddress/memWriteData SHALL hold last-driven values; memWriteEnable=0.

Reset
REQ-033 resetN low SHALL asynchronously force IDLE, ifAck=0, dAck=0, ifData=0, dRData=0, memAddress=0, memWriteData=0, memWriteEnable=0, busy=0.
REQ-034 After reset, lastGrant SHALL select the fetch port to win the first tie.
REQ-035 Reset during any access SHALL abort it with no ack; reset during D_WR drops memWriteEnable immediately.

Verification
REQ-036 MEM[0x10]=0x34, MEM[0x11]=0x12; fetch 0x0010 -> ifAck at n+3, ifData=0x1234, busy high 2 cycles.
REQ-037 Write 0xA5 to 0x0005 then read 0x0005 -> memWriteEnable high exactly 1 cycle, dAck at n+2 each, dRData=0xA5.
REQ-038 ifReq and dReq both high from reset, held through acks -> grant order fetch, data, fetch, data; no ack ever double-pulses.
REQ-039 Fetch at 0xFFFF with MEM[0xFFFF]=0xCD, MEM[0x0000]=0xAB -> ifData=0xABCD.
REQ-040 resetN low during D_WR -> memWriteEnable falls without clock edge, target byte unchanged, no dAck.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port byte memory between a 16-bit fetch port and a byte data port
//   clk, resetN                       : clock, asynchronous active-low reset
//   ifReq/ifAddr -> ifAck/ifData      : fetch request (held until ack), returns {MEM[a+1], MEM[a]}
//   dReq/dWe/dAddr/dWData -> dAck/dRData : data read or write of one byte
//   memAddress/memWriteData/memWriteEnable, memReadData : shared memory with combinational read
//   busy                              : high while an access is in progress
module mem_port_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifAck,
    output logic [15:0]       ifData,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [7:0]        dWData,
    output logic              dAck,
    output logic [7:0]        dRData,
    output logic [ADDR_W-1:0] memAddress,
    output logic [7:0]        memWriteData,
    output logic              memWriteEnable,
    input  logic [7:0]        memReadData,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, IF_LO, IF_HI, D_RD, D_WR} state_t;
    state_t state, state_nxt;
    logic if_elig, d_elig, grant_if, grant_d, last_d;
    // a port whose ack is still high this cycle is finishing, not re-requesting
    always_comb begin
        if_elig   = ifReq && !ifAck;
        d_elig    = dReq && !dAck;
        grant_if  = (state == IDLE) && if_elig && (!d_elig || last_d);
        grant_d   = (state == IDLE) && d_elig && !grant_if;
        state_nxt = grant_if ? IF_LO :
                    grant_d ? (dWe ? D_WR : D_RD) :
                    (state == IF_LO) ? IF_HI : IDLE;
    end
    always_ff @(posedge clk or negedge resetN)
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    assign memWriteEnable = (state == D_WR);
    assign busy           = (state != IDLE);
    // memAddress doubles as the latched request address and steps to addr+1 for the high fetch byte
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            ifAck        <= 1'b0;
            dAck         <= 1'b0;
            ifData       <= '0;
            dRData       <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
            last_d       <= 1'b1;
        end else begin
            ifAck <= (state == IF_HI);
            dAck  <= (state == D_RD) || (state == D_WR);
            if (grant_if) begin
                memAddress <= ifAddr;
                last_d     <= 1'b0;
            end
            if (grant_d) begin
                memAddress <= dAddr;
                last_d     <= 1'b1;
                if (dWe)
                    memWriteData <= dWData;
            end
            if (state == IF_LO) begin
                ifData[7:0] <= memReadData;
                memAddress  <= memAddress + ADDR_W'(1);
            end
            if (state == IF_HI)
                ifData[15:8] <= memReadData;
            if (state == D_RD)
                dRData <= memReadData;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level memory model
module tb_mem_port_arbiter;
    logic        clk = 1'b0, resetN = 1'b0;
    logic        ifReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
    logic [15:0] ifAddr = '0, dAddr = '0;
    logic [7:0]  dWData = '0;
    logic        ifAck, dAck, memWriteEnable, busy;
    logic [15:0] ifData, memAddress;
    logic [7:0]  dRData, memWriteData, memReadData;
    logic        poke_en = 1'b0;
    logic [15:0] poke_a = '0;
    logic [7:0]  poke_d = '0;
    logic [7:0]  mem [0:65535];
    bit          memv [0:65535];
    logic [7:0]  ref_mem [0:65535];
    bit          refv [0:65535];
    int          checks = 0, errors = 0;
    bit          last_d = 1'b1;
    logic [7:0]  last_rd = '0;

    mem_port_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .resetN(resetN),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifData(ifData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dAck(dAck), .dRData(dRData),
        .memAddress(memAddress), .memWriteData(memWriteData), .memWriteEnable(memWriteEnable),
        .memReadData(memReadData), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] phys(input logic [15:0] a);
        return memv[a] ? mem[a] : pat(a);
    endfunction
    function automatic logic [7:0] rref(input logic [15:0] a);
        return refv[a] ? ref_mem[a] : pat(a);
    endfunction

    assign memReadData = phys(memAddress);
    always @(posedge clk)
        if (memWriteEnable) begin
            mem[memAddress]  <= memWriteData;
            memv[memAddress] <= 1'b1;
        end else if (poke_en) begin
            mem[poke_a]  <= poke_d;
            memv[poke_a] <= 1'b1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic ref_write(input logic [15:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        refv[a] = 1'b1;
    endtask
    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        tick();
        poke_en = 1'b0;
        ref_write(a, d);
    endtask

    task automatic do_fetch(input logic [15:0] a);
        int lat = 0, bsy = 0;
        logic [15:0] exp;
        exp = {rref(a + 16'd1), rref(a)};
        ifReq = 1'b1; ifAddr = a;
        do begin
            tick(); lat++;
            if (busy) bsy++;
            if (lat == 1) ifAddr = 16'($urandom);
        end while (!ifAck && lat < 20);
        ifReq = 1'b0;
        chk("if_latency", lat, 3);
        chk("if_data", ifData, exp);
        chk("if_busy_cycles", bsy, 2);
        last_d = 1'b0;
        tick();
        chk("if_ack_single", ifAck, 0);
    endtask

    task automatic do_data(input bit we, input logic [15:0] a, input logic [7:0] d);
        int lat = 0, wec = 0;
        logic [7:0] exp;
        exp = rref(a);
        dReq = 1'b1; dWe = we; dAddr = a; dWData = d;
        do begin
            tick(); lat++;
            if (memWriteEnable) wec++;
            if (lat == 1) begin dAddr = 16'($urandom); dWData = 8'($urandom); dWe = ~we; end
        end while (!dAck && lat < 20);
        dReq = 1'b0;
        chk("d_latency", lat, 2);
        chk("d_we_cycles", wec, we ? 1 : 0);
        if (we) begin
            ref_write(a, d);
            chk("d_write_mem", phys(a), d);
            chk("d_rdata_hold", dRData, last_rd);
        end else begin
            chk("d_rdata", dRData, exp);
            last_rd = exp;
        end
        last_d = 1'b1;
        tick();
        chk("d_ack_single", dAck, 0);
    endtask

    // both ports request in the same idle cycle; the round-robin flag decides the order
    task automatic do_pair(input bit we, input logic [15:0] fa, input logic [15:0] da, input logic [7:0] dd);
        bit win_if;
        int t = 0, ti = 0, td = 0;
        logic [15:0] eif;
        logic [7:0] erd;
        win_if = last_d;
        erd = rref(da);
        if (win_if) begin
            eif = {rref(fa + 16'd1), rref(fa)};
            if (we) ref_write(da, dd);
        end else begin
            if (we) ref_write(da, dd);
            eif = {rref(fa + 16'd1), rref(fa)};
        end
        ifReq = 1'b1; ifAddr = fa;
        dReq = 1'b1; dWe = we; dAddr = da; dWData = dd;
        do begin
            tick(); t++;
            if (ifAck) begin
                ti = t; ifReq = 1'b0;
                chk("pair_if_data", ifData, eif);
            end
            if (dAck) begin
                td = t; dReq = 1'b0;
                chk("pair_d_rdata", dRData, we ? last_rd : erd);
            end
        end while ((ti == 0 || td == 0) && t < 30);
        ifReq = 1'b0; dReq = 1'b0;
        if (!we) last_rd = erd;
        chk("pair_if_cycle", ti, win_if ? 3 : 5);
        chk("pair_d_cycle", td, win_if ? 5 : 2);
        last_d = win_if;
        tick();
        chk("pair_idle_acks", {ifAck, dAck}, 0);
    endtask

    initial begin
        logic [15:0] wa;
        logic [7:0]  wd;
        bit q [$];
        bit prev_if, prev_d;
        ifReq = 1'b1; ifAddr = 16'h0010;
        dReq = 1'b1; dAddr = 16'h0020; dWe = 1'b0;
        repeat (2) tick();
        chk("rst_ifAck", ifAck, 0);
        chk("rst_dAck", dAck, 0);
        chk("rst_ifData", ifData, 0);
        chk("rst_dRData", dRData, 0);
        chk("rst_memAddress", memAddress, 0);
        chk("rst_memWriteData", memWriteData, 0);
        chk("rst_memWriteEnable", memWriteEnable, 0);
        chk("rst_busy", busy, 0);

        // both requests held from reset: fetch wins the first tie, then strict alternation
        resetN = 1'b1;
        prev_if = 1'b0; prev_d = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("no_double_if", ifAck && prev_if, 0);
            chk("no_double_d", dAck && prev_d, 0);
            if (ifAck) begin
                q.push_back(1'b1);
                chk("tie_if_data", ifData, {rref(16'h0011), rref(16'h0010)});
            end
            if (dAck) begin
                q.push_back(1'b0);
                chk("tie_d_rdata", dRData, rref(16'h0020));
            end
            prev_if = ifAck; prev_d = dAck;
        end
        chk("tie_events", q.size(), 6);
        for (int i = 0; i < 6 && i < q.size(); i++)
            chk("tie_order", q[i], (i % 2 == 0) ? 1 : 0);
        ifReq = 1'b0; dReq = 1'b0;
        repeat (5) tick();
        last_d = 1'b0;
        last_rd = rref(16'h0020);
        chk("tie_idle", busy, 0);

        poke(16'h0010, 8'h34);
        poke(16'h0011, 8'h12);
        do_fetch(16'h0010);
        chk("fetch_0010_value", ifData, 16'h1234);

        do_data(1'b1, 16'h0005, 8'hA5);
        do_data(1'b0, 16'h0005, 8'h00);
        chk("read_0005_value", dRData, 8'hA5);

        poke(16'hFFFF, 8'hCD);
        poke(16'h0000, 8'hAB);
        do_fetch(16'hFFFF);
        chk("fetch_wrap_value", ifData, 16'hABCD);

        for (int i = 0; i < 30; i++) begin
            wa = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            wd = 8'($urandom);
            case ($urandom_range(0, 2))
                0: do_fetch(wa);
                1: do_data(1'b1, wa, wd);
                default: do_data(1'b0, wa, wd);
            endcase
        end
        for (int i = 0; i < 20; i++) begin
            wa = 16'($urandom_range(0, 15));
            do_pair(1'($urandom), 16'($urandom_range(0, 15)), wa, 8'($urandom));
        end

        // reset in the middle of a write must drop the strobe at once and leave memory untouched
        wd = ~rref(16'h0040);
        dReq = 1'b1; dWe = 1'b1; dAddr = 16'h0040; dWData = wd;
        tick();
        chk("dwr_we_high", memWriteEnable, 1);
        #2 resetN = 1'b0;
        #1;
        chk("rst_async_we", memWriteEnable, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_addr", memAddress, 0);
        dReq = 1'b0;
        repeat (2) tick();
        chk("rst_mem_unchanged", phys(16'h0040), rref(16'h0040));
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_dack", dAck, 0);
        end
        last_d = 1'b1;
        last_rd = 8'h00;
        do_data(1'b0, 16'h0040, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
